// File: rtl/inertial_pulse_filter.sv
// inertial_pulse_filter: inertial/transport delay stage; INERTIAL_REJECT_CNT_EN adds reject_cnt
module inertial_pulse_filter #(
   parameter int               WIDTH     = 1,
   parameter int               DELAY     = 5,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode_transport,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_chg,
   output logic             reject,
   output logic             busy
`ifdef INERTIAL_REJECT_CNT_EN
   ,
   output logic [CNT_W-1:0] reject_cnt
`endif
);
   localparam int CW = $clog2(DELAY + 1);
   localparam logic STABLE = 1'b0;
   localparam logic PEND   = 1'b1;
   logic                        state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [WIDTH-1:0]            pend_q, pend_d, dout_q, dout_d;
   logic                        chg_q, chg_d, rej_q, rej_d;
   logic [DELAY-1:0][WIDTH-1:0] pipe_q, pipe_d;
   always_comb begin
      pipe_d = pipe_q;
      pipe_d[0] = din;
      for (int k = 1; k < DELAY; k++) pipe_d[k] = pipe_q[k-1];
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      dout_d  = dout_q;
      rej_d   = 1'b0;
      if (mode_transport) begin
         dout_d  = pipe_q[DELAY-1];
         state_d = STABLE;
         cnt_d   = '0;
      end else if (state_q == STABLE) begin
         if (din != dout_q) begin
            pend_d = din;
            cnt_d  = CW'(1);
            if (DELAY == 1) dout_d = din;
            else state_d = PEND;
         end
      end else if (din == pend_q) begin
         cnt_d = (cnt_q == CW'(DELAY)) ? cnt_q : cnt_q + CW'(1);
         if (cnt_q + CW'(1) == CW'(DELAY)) begin
            dout_d  = pend_q;
            state_d = STABLE;
         end
      end else if (din == dout_q) begin
         state_d = STABLE;
         rej_d   = 1'b1;
      end else begin
         pend_d = din;
         cnt_d  = CW'(1);
      end
      chg_d = dout_d != dout_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         pend_q  <= RESET_VAL;
         dout_q  <= RESET_VAL;
         chg_q   <= 1'b0;
         rej_q   <= 1'b0;
         pipe_q  <= {DELAY{RESET_VAL}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         dout_q  <= dout_d;
         chg_q   <= chg_d;
         rej_q   <= rej_d;
         pipe_q  <= pipe_d;
      end
   end
`ifdef INERTIAL_REJECT_CNT_EN
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   always_comb rcnt_d = (rej_d && !(&rcnt_q)) ? rcnt_q + CNT_W'(1) : rcnt_q;
   always_ff @(posedge clk) begin
      if (!rst_n) rcnt_q <= '0;
      else rcnt_q <= rcnt_d;
   end
   assign reject_cnt = rcnt_q;
`endif
   assign dout     = dout_q;
   assign dout_chg = chg_q;
   assign reject   = rej_q;
   // a PEND left over from the last inertial edge is not reported once transport is selected
   assign busy     = (state_q == PEND) && !mode_transport;
endmodule
